// File: rtl/kf_pkg.sv
// Shared types and arithmetic helpers for the Kalman state-vector datapath.
// Define KF_SATURATE_EN to make write-back clamp instead of wrap.
package kf_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P_MAC   = 3'd1,
    P_DONE  = 3'd2,
    U_INNOV = 3'd3,
    U_GAIN  = 3'd4,
    U_DONE  = 3'd5
  } kf_est_state_t;

  // Full product width plus growth for nos+1 terms plus one guard bit.
  function automatic int unsigned kf_acc_w(input int unsigned width, input int unsigned n);
    return 2 * width + $clog2(n + 1) + 1;
  endfunction

`ifdef KF_SATURATE_EN
  // Fixed container width; accumulator widths up to this size are supported.
  localparam int unsigned SatW = 128;

  function automatic logic signed [SatW-1:0] sat_narrow(input logic signed [SatW-1:0] v,
                                                        input int unsigned w);
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    hi = $signed((128'd1 << (w - 1)) - 128'd1);
    lo = -hi - 128'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction
`endif

endpackage

// File: rtl/kf_mac.sv
// Shared signed fixed-point multiply-accumulate unit; res is the scaled, narrowed
// value the accumulator will hold after this edge, so rows can retire on their last product.
module kf_mac
  import kf_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16,
  parameter int unsigned ACC_W = 68
) (
  input  logic                    clk,
  input  logic                    clk_en,
  input  logic                    clear,
  input  logic                    preload,
  input  logic                    sub,
  input  logic signed [WIDTH-1:0] pre,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [WIDTH-1:0] res
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   base;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   shifted;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W - 2 * WIDTH){prod[2*WIDTH-1]}}, prod};

  always_comb begin
    if (clear) begin
      base = '0;
    end else if (preload) begin
      base = {{(ACC_W - WIDTH){pre[WIDTH-1]}}, pre} <<< FRAC;
    end else begin
      base = acc;
    end
    acc_d = sub ? (base - prod_ext) : (base + prod_ext);
  end

  // Arithmetic shift: truncation toward minus infinity.
  assign shifted = acc_d >>> FRAC;

`ifdef KF_SATURATE_EN
  logic signed [SatW-1:0] sat;
  logic                   unused_sat;
  assign sat        = sat_narrow({{(SatW - ACC_W){shifted[ACC_W-1]}}, shifted}, WIDTH);
  assign res        = sat[WIDTH-1:0];
  assign unused_sat = ^sat[SatW-1:WIDTH];
`else
  logic unused_shift;
  assign res          = shifted[WIDTH-1:0];
  assign unused_shift = ^shifted[ACC_W-1:WIDTH];
`endif

  always_ff @(posedge clk) begin
    if (clk_en) begin
      acc <= acc_d;
    end
  end

endmodule

// File: rtl/kf_state_estimator.sv
// Kalman state-vector datapath: time update and measurement update on one shared MAC.
// Write-back saturates when KF_SATURATE_EN is defined, otherwise wraps.
module kf_state_estimator
  import kf_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned nos       = 4,
  parameter int unsigned noo       = 2,
  parameter int unsigned intDigits = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             Start_Prediction,
  input  logic             Start_Update,
  input  logic [WIDTH-1:0] A      [nos][nos],
  input  logic [WIDTH-1:0] B      [nos],
  input  logic [WIDTH-1:0] C      [noo][nos],
  input  logic [WIDTH-1:0] K      [nos][noo],
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] y      [noo],
  input  logic [WIDTH-1:0] x0     [nos],
  output logic [WIDTH-1:0] x_pred [nos],
  output logic [WIDTH-1:0] x_hat  [nos],
  output logic [WIDTH-1:0] innov  [noo],
  output logic             end_Prediction,
  output logic             end_Update
);

  localparam int unsigned FRAC  = WIDTH - intDigits;
  localparam int unsigned ACC_W = kf_acc_w(WIDTH, nos);
  localparam int unsigned MAXN  = (nos > noo) ? nos : noo;
  localparam int unsigned CW    = $clog2(MAXN + 1);

  kf_est_state_t state_q;
  logic [CW-1:0] row_q;
  logic [CW-1:0] col_q;

  logic                    mac_clear;
  logic                    mac_preload;
  logic                    mac_sub;
  logic signed [WIDTH-1:0] mac_pre;
  logic signed [WIDTH-1:0] mac_a;
  logic signed [WIDTH-1:0] mac_b;
  logic signed [WIDTH-1:0] mac_res;
  logic signed [ACC_W-1:0] unused_acc;
  logic                    col_end;
  logic                    row_end;

  kf_mac #(
    .WIDTH(WIDTH),
    .FRAC (FRAC),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk    (clk),
    .clk_en (clk_en),
    .clear  (mac_clear),
    .preload(mac_preload),
    .sub    (mac_sub),
    .pre    (mac_pre),
    .a      (mac_a),
    .b      (mac_b),
    .acc    (unused_acc),
    .res    (mac_res)
  );

  // Operand selection; col_q walks the terms of the row selected by row_q.
  always_comb begin
    mac_clear   = 1'b1;
    mac_preload = 1'b0;
    mac_sub     = 1'b0;
    mac_pre     = '0;
    mac_a       = '0;
    mac_b       = '0;
    col_end     = 1'b0;
    row_end     = 1'b0;
    case (state_q)
      P_MAC: begin
        mac_clear = (col_q == '0);
        col_end   = (col_q == CW'(nos));
        row_end   = (row_q == CW'(nos - 1));
        for (int i = 0; i < nos; i++) begin
          if (row_q == CW'(i)) begin
            if (col_end) begin
              mac_a = B[i];
              mac_b = u;
            end
            for (int j = 0; j < nos; j++) begin
              if (col_q == CW'(j)) begin
                mac_a = A[i][j];
                mac_b = x_hat[j];
              end
            end
          end
        end
      end
      U_INNOV: begin
        mac_clear   = 1'b0;
        mac_preload = (col_q == '0);
        mac_sub     = 1'b1;
        col_end     = (col_q == CW'(nos - 1));
        row_end     = (row_q == CW'(noo - 1));
        for (int r = 0; r < noo; r++) begin
          if (row_q == CW'(r)) begin
            mac_pre = y[r];
            for (int j = 0; j < nos; j++) begin
              if (col_q == CW'(j)) begin
                mac_a = C[r][j];
                mac_b = x_pred[j];
              end
            end
          end
        end
      end
      U_GAIN: begin
        mac_clear   = 1'b0;
        mac_preload = (col_q == '0);
        col_end     = (col_q == CW'(noo - 1));
        row_end     = (row_q == CW'(nos - 1));
        for (int i = 0; i < nos; i++) begin
          if (row_q == CW'(i)) begin
            mac_pre = x_pred[i];
            for (int r = 0; r < noo; r++) begin
              if (col_q == CW'(r)) begin
                mac_a = K[i][r];
                mac_b = innov[r];
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (reset) begin
        state_q <= IDLE;
        row_q   <= '0;
        col_q   <= '0;
        x_pred  <= x0;
        x_hat   <= x0;
        for (int r = 0; r < noo; r++) begin
          innov[r] <= '0;
        end
      end else begin
        case (state_q)
          IDLE, U_DONE: begin
            if (Start_Prediction) begin
              state_q <= P_MAC;
              row_q   <= '0;
              col_q   <= '0;
            end
          end
          P_DONE: begin
            if (Start_Update) begin
              state_q <= U_INNOV;
              row_q   <= '0;
              col_q   <= '0;
            end else if (Start_Prediction) begin
              state_q <= P_MAC;
              row_q   <= '0;
              col_q   <= '0;
            end
          end
          P_MAC, U_INNOV, U_GAIN: begin
            if (col_end) begin
              col_q <= '0;
              row_q <= row_end ? '0 : row_q + 1'b1;
              for (int i = 0; i < nos; i++) begin
                if (row_q == CW'(i)) begin
                  if (state_q == P_MAC) x_pred[i] <= mac_res;
                  if (state_q == U_GAIN) x_hat[i] <= mac_res;
                end
              end
              for (int r = 0; r < noo; r++) begin
                if (state_q == U_INNOV && row_q == CW'(r)) innov[r] <= mac_res;
              end
              if (row_end) begin
                state_q <= (state_q == P_MAC)   ? P_DONE :
                           (state_q == U_INNOV) ? U_GAIN : U_DONE;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign end_Prediction = (state_q == P_DONE);
  assign end_Update     = (state_q == U_DONE);

endmodule
